// File: rtl/mse_serial_master.sv
// Serial-command to Avalon-MM bridge: a framed bit stream on sdi/sle becomes one
// bus read or write, and the result is returned serially on sdo/srdy.
module mse_serial_master #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sdi,
   input  logic                  sle,
   output logic                  sdo,
   output logic                  srdy,
   output logic                  serr,
   output logic                  rso_MRST_reset,
   output logic                  cso_MCLK_clk,
   output logic [ADDR_W-1:0]     avm_M1_address,
   output logic [DATA_W-1:0]     avm_M1_writedata,
   input  logic [DATA_W-1:0]     avm_M1_readdata,
   output logic [DATA_W/8-1:0]   avm_M1_byteenable,
   output logic                  avm_M1_write,
   output logic                  avm_M1_read,
   output logic                  avm_M1_begintransfer,
   input  logic                  avm_M1_readdatavalid,
   input  logic                  avm_M1_waitrequest
);

   // state     | meaning
   // IDLE      | waiting for sle=1 to start a frame
   // SHIFT_IN  | shifting command bits while sle=1
   // CHECK     | frame length checked against the op bit
   // BUS_REQ   | read/write held until waitrequest=0
   // WAIT_RDV  | read accepted, waiting for readdatavalid
   // SHIFT_OUT | read data serialised MSB first on sdo
   // DONE      | write acknowledge (sdo=0) for one cycle
   // ERROR     | bad length or timeout (sdo=1, serr=1) for one cycle

   localparam int LEN_R   = 1 + ADDR_W;
   localparam int LEN_W   = 1 + ADDR_W + DATA_W;
   localparam int CNT_MAX = LEN_W + 1;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int SR_W    = ADDR_W + DATA_W;
   localparam int SO_W    = $clog2(DATA_W);

   typedef enum logic [2:0] {
      S_IDLE, S_SHIFT_IN, S_CHECK, S_BUS_REQ, S_WAIT_RDV, S_SHIFT_OUT, S_DONE, S_ERROR
   } state_t;

   state_t              state;
   logic                op_q;
   logic [SR_W-1:0]     sr_q;
   logic [CNT_W-1:0]    bit_cnt;
   logic [15:0]         tmo_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [SO_W-1:0]     so_cnt;
   logic [15:0]         tmo_nxt;
   logic                tmo_hit;
   logic                len_ok;

   assign rso_MRST_reset = reset;
   assign cso_MCLK_clk   = clk;

   assign tmo_nxt = tmo_q + 16'd1;
   assign tmo_hit = (tmo_nxt == 16'(TIMEOUT));
   assign len_ok  = op_q ? (bit_cnt == CNT_W'(LEN_W)) : (bit_cnt == CNT_W'(LEN_R));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                <= S_IDLE;
         op_q                 <= 1'b0;
         sr_q                 <= '0;
         bit_cnt              <= '0;
         tmo_q                <= '0;
         rdata_q              <= '0;
         so_cnt               <= '0;
         sdo                  <= 1'b0;
         srdy                 <= 1'b0;
         serr                 <= 1'b0;
         avm_M1_address       <= '0;
         avm_M1_writedata     <= '0;
         avm_M1_byteenable    <= '0;
         avm_M1_write         <= 1'b0;
         avm_M1_read          <= 1'b0;
         avm_M1_begintransfer <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (sle) begin
                  op_q    <= sdi;
                  sr_q    <= '0;
                  bit_cnt <= CNT_W'(1);
                  state   <= S_SHIFT_IN;
               end
            end
            S_SHIFT_IN: begin
               if (sle) begin
                  sr_q <= {sr_q[SR_W-2:0], sdi};
                  if (bit_cnt != CNT_W'(CNT_MAX)) bit_cnt <= bit_cnt + 1'b1;
               end else begin
                  state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (len_ok) begin
                  tmo_q                <= '0;
                  avm_M1_begintransfer <= 1'b1;
                  avm_M1_byteenable    <= '1;
                  if (op_q) begin
                     avm_M1_write     <= 1'b1;
                     avm_M1_address   <= sr_q[SR_W-1:DATA_W];
                     avm_M1_writedata <= sr_q[DATA_W-1:0];
                  end else begin
                     avm_M1_read      <= 1'b1;
                     avm_M1_address   <= sr_q[ADDR_W-1:0];
                  end
                  state <= S_BUS_REQ;
               end else begin
                  serr  <= 1'b1;
                  srdy  <= 1'b1;
                  sdo   <= 1'b1;
                  state <= S_ERROR;
               end
            end
            S_BUS_REQ: begin
               avm_M1_begintransfer <= 1'b0;
               if (!avm_M1_waitrequest) begin
                  avm_M1_read       <= 1'b0;
                  avm_M1_write      <= 1'b0;
                  avm_M1_byteenable <= '0;
                  if (avm_M1_write) begin
                     srdy  <= 1'b1;
                     sdo   <= 1'b0;
                     state <= S_DONE;
                  end else if (avm_M1_readdatavalid) begin
                     rdata_q <= avm_M1_readdata;
                     sdo     <= avm_M1_readdata[DATA_W-1];
                     srdy    <= 1'b1;
                     so_cnt  <= SO_W'(DATA_W - 1);
                     state   <= S_SHIFT_OUT;
                  end else begin
                     tmo_q <= tmo_nxt;
                     state <= S_WAIT_RDV;
                  end
               end else if (tmo_hit) begin
                  avm_M1_read       <= 1'b0;
                  avm_M1_write      <= 1'b0;
                  avm_M1_byteenable <= '0;
                  serr              <= 1'b1;
                  srdy              <= 1'b1;
                  sdo               <= 1'b1;
                  state             <= S_ERROR;
               end else begin
                  tmo_q <= tmo_nxt;
               end
            end
            S_WAIT_RDV: begin
               if (avm_M1_readdatavalid) begin
                  rdata_q <= avm_M1_readdata;
                  sdo     <= avm_M1_readdata[DATA_W-1];
                  srdy    <= 1'b1;
                  so_cnt  <= SO_W'(DATA_W - 1);
                  state   <= S_SHIFT_OUT;
               end else if (tmo_hit) begin
                  serr  <= 1'b1;
                  srdy  <= 1'b1;
                  sdo   <= 1'b1;
                  state <= S_ERROR;
               end else begin
                  tmo_q <= tmo_nxt;
               end
            end
            S_SHIFT_OUT: begin
               // so_cnt counts the bits still to present after the current one
               if (so_cnt == '0) begin
                  srdy  <= 1'b0;
                  sdo   <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  so_cnt  <= so_cnt - 1'b1;
                  rdata_q <= rdata_q << 1;
                  sdo     <= rdata_q[DATA_W-2];
               end
            end
            S_DONE: begin
               srdy  <= 1'b0;
               sdo   <= 1'b0;
               state <= S_IDLE;
            end
            S_ERROR: begin
               serr  <= 1'b0;
               srdy  <= 1'b0;
               sdo   <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
